// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder: split stage, log2(WIDTH) prefix levels, then a sum stage.
// Defining PREFIX_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).

module prefix_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PREFIX_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  // Handshake: a beat moves on an edge where valid && ready. in_ready mirrors the global
  // advance, so the whole pipe moves or holds as one. out_valid, sum and cout hold while out_ready=0.
  logic             advance;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Stage taps. Bit 0 of the g/p vectors is carry position -1, which holds cin.
  wire [LEVELS:0][WIDTH:0]   g_s;
  wire [LEVELS:0][WIDTH:0]   p_s;
  wire [LEVELS:0][WIDTH-1:0] praw_s;
  wire [LEVELS:0]            v_s;

  for (genvar k = 0; k <= LEVELS; k++) begin : gen_stage
    logic [WIDTH:0]   g_d, g_q;
    logic [WIDTH:0]   p_d, p_q;
    logic [WIDTH-1:0] praw_d, praw_q;
    logic             vld_d, vld_q;

    if (k == 0) begin : gen_split
      always_comb begin
        vld_d  = vld_q;
        g_d    = g_q;
        p_d    = p_q;
        praw_d = praw_q;
        if (advance) begin
          vld_d  = in_valid;
          g_d    = {a & b, cin};
          p_d    = {a ^ b, 1'b0};
          praw_d = a ^ b;
        end
      end
    end else begin : gen_merge
      localparam int D = 1 << (k - 1);
      // Positions whose low partner would fall below carry position -1 keep their P unchanged.
      localparam logic [WIDTH:0] LOW_MASK = ~({(WIDTH+1){1'b1}} << D);

      always_comb begin
        vld_d  = vld_q;
        g_d    = g_q;
        p_d    = p_q;
        praw_d = praw_q;
        if (advance) begin
          vld_d  = v_s[k-1];
          praw_d = praw_s[k-1];
          g_d    = g_s[k-1] | (p_s[k-1] & (g_s[k-1] << D));
          p_d    = p_s[k-1] & ((p_s[k-1] << D) | LOW_MASK);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
      g_q    <= g_d;
      p_q    <= p_d;
      praw_q <= praw_d;
    end

    assign g_s[k]    = g_q;
    assign p_s[k]    = p_q;
    assign praw_s[k] = praw_q;
    assign v_s[k]    = vld_q;
  end

  // After LEVELS merges the top position still spans only real bits, so cin is folded in here.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (advance) begin
      out_valid_d = v_s[LEVELS];
      if (v_s[LEVELS]) begin
        sum_d  = praw_s[LEVELS] ^ g_s[LEVELS][WIDTH-1:0];
        cout_d = g_s[LEVELS][WIDTH] | (p_s[LEVELS][WIDTH] & g_s[LEVELS][0]);
        ovf_d  = cout_d ^ g_s[LEVELS][WIDTH-1];
      end else begin
        sum_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef PREFIX_ADDER_OVF_EN
  assign ovf = ovf_q;
  wire unused_ovf = 1'b0;
`else
  wire unused_ovf = ovf_q;
`endif

  // Only the top bit of the final group-propagate vector feeds the result.
  wire unused_p_low = &{1'b0, p_s[LEVELS][WIDTH-1:0]};

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe: reset, carry chains, throughput, stall, mid-flight reset
// and overflow vectors (ovf checked when PREFIX_ADDER_OVF_EN is defined).

module tb_prefix_adder_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PREFIX_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PREFIX_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // driver tasks
  task step();
    @(posedge clk);
    #1;
  endtask

  task send_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, output int lat);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    lat      = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      in_valid = 1'b0;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %0b expected 0", cout); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
`endif
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %0b expected 0", out_valid); end
  endtask

  task test_carry_chain();
    int lat;
    send_one(16'h0001, 16'hFFFF, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL carry_latency: got %0d expected 6", lat); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %0b expected 1", cout); end
  endtask

  task test_back_to_back();
    int n;
    in_valid = 1'b1;
    a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
    step();
    a = 16'h1234; b = 16'h4321; cin = 1'b0;
    step();
    in_valid = 1'b0;
    n = 2;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL b2b_latency: got %0d expected 6", n); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL b2b_sum0: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_cout0: got %0b expected 1", cout); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %0b expected 1", out_valid); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL b2b_sum1: got %h expected 5555", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_cout1: got %0b expected 0", cout); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b expected 0", out_valid); end
  endtask

  task test_throughput();
    int i;
    logic [W-1:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        a   = W'(c);
        b   = W'(3 * c);
        cin = c[0];
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_in_ready c=%0d: got %0b expected 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step();
      i = c - 5;
      if (i >= 0 && i < 16) begin
        e = W'(4 * i + (i % 2));
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tput_valid i=%0d: got %0b expected 1", i, out_valid); end
        checks++; if (sum !== e) begin errors++; $display("FAIL tput_sum i=%0d: got %h expected %h", i, sum, e); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tput_idle c=%0d: got %0b expected 0", c, out_valid); end
      end
    end
  endtask

  task test_stall();
    int sent;
    int got;
    logic [W:0] held;
    logic [W:0] e;
    sent = 0;
    got  = 0;
    held = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      out_ready = !(cyc >= 8 && cyc < 12);
      #1;
      if (cyc >= 8 && cyc < 12) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d: got %0b expected 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d: got %0b expected 1", cyc, out_valid); end
        if (cyc == 8) begin
          held = {cout, sum};
        end else begin
          checks++; if ({cout, sum} !== held) begin errors++; $display("FAIL stall_hold cyc=%0d: got %h expected %h", cyc, {cout, sum}, held); end
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stall_extra: got %h expected no beat", {cout, sum});
        end else begin
          e = exp_q.pop_front();
          checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL stall_data beat=%0d: got %h expected %h", got, {cout, sum}, e); end
        end
        got++;
      end
      if (sent < 12) begin
        in_valid = 1'b1;
        a   = W'(32'h1111 * sent + 32'h0FF0);
        b   = W'(32'hF00F + 32'h0123 * sent);
        cin = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        sent++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 12) begin errors++; $display("FAIL stall_count: got %0d expected 12", got); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stall_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task test_reset_mid();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a   = W'(16'h0100 + i);
      b   = W'(16'h0020 * i);
      cin = 1'b0;
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid n=%0d: got %0b expected 0", n, out_valid); end
      checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midreset_sum n=%0d: got %h expected 0000", n, sum); end
      step();
    end
    send_one(16'h00FF, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL midreset_latency: got %0d expected 6", lat); end
    checks++; if (sum !== 16'h0100) begin errors++; $display("FAIL midreset_sum_new: got %h expected 0100", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midreset_cout_new: got %0b expected 0", cout); end
  endtask

  task test_ovf_vectors();
    int lat;
    send_one(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL ovf1_sum: got %h expected 8000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ovf1_cout: got %0b expected 0", cout); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf: got %0b expected 1", ovf); end
`endif
    send_one(16'h8000, 16'h8000, 1'b0, lat);
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL ovf2_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf2_cout: got %0b expected 1", cout); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf2_ovf: got %0b expected 1", ovf); end
`endif
    send_one(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL ovf3_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf3_cout: got %0b expected 1", cout); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf3_ovf: got %0b expected 0", ovf); end
`endif
    checks++; if (lat !== 6) begin errors++; $display("FAIL ovf3_latency: got %0d expected 6", lat); end
  endtask

  // final report
  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_throughput();
    test_stall();
    test_reset_mid();
    test_ovf_vectors();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
